// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit: per-stage register-usage
// record, forward-select encoding and the id-match helpers.
package hazard_pkg;

  localparam int REG_ID_W = 5;
  localparam int CNT_W    = 32;

  typedef struct packed {
    logic [REG_ID_W-1:0] dst;
    logic [REG_ID_W-1:0] rs;
    logic [REG_ID_W-1:0] rt;
    logic                reg_write;
    logic                mem_to_reg;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  // $0 is hard-wired, so it never counts as a dependency.
  function automatic logic id_hit(input logic [REG_ID_W-1:0] a,
                                  input logic [REG_ID_W-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  function automatic fwd_sel_e fwd_sel(input logic [REG_ID_W-1:0] src,
                                       input stage_info_t m,
                                       input stage_info_t w);
    if (m.reg_write && id_hit(src, m.dst)) return FWD_M;
    if (w.reg_write && id_hit(src, w.dst)) return FWD_W;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle shared by the pipeline control blocks.
interface ctrl_bus_if;
  logic clk;
  logic rst_n;

  modport central (input clk, input rst_n);
endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: stage_info_t register with async clear and
// a synchronous bubble insert.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bubble,
  input  stage_info_t i_d,
  output stage_info_t o_q
);

  stage_info_t r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_q <= BUBBLE;
    else if (i_bubble) r_q <= BUBBLE;
    else               r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard-resolution unit: forward selects and stall/flush from a private
// E/M/W shadow pipeline. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
(
  ctrl_bus_if.central         ctrl_bus,
  input  logic [REG_ID_W-1:0] rs_D,
  input  logic [REG_ID_W-1:0] rt_D,
  input  logic [REG_ID_W-1:0] dst_D,
  input  logic                reg_write_D,
  input  logic                mem_to_reg_D,
  input  logic                branch_D,
  input  logic                pc_src_D,
  output logic                stall_F,
  output logic                stall_D,
  output logic                flush_D,
  output logic                flush_E,
  output logic                forwardA_D,
  output logic                forwardB_D,
  output logic [1:0]          forwardA_E,
  output logic [1:0]          forwardB_E,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  stage_info_t w_d_info;
  stage_info_t w_e;
  stage_info_t w_m;
  stage_info_t w_w;
  logic        w_lw_stall;
  logic        w_br_stall;
  logic        w_stall;
  logic        w_unused;

  assign w_d_info = '{dst: dst_D, rs: rs_D, rt: rt_D,
                      reg_write: reg_write_D, mem_to_reg: mem_to_reg_D};

  hazard_stage_reg u_stage_e (
    .i_clk(ctrl_bus.clk), .i_rst_n(ctrl_bus.rst_n), .i_bubble(w_stall),
    .i_d(w_d_info), .o_q(w_e)
  );

  hazard_stage_reg u_stage_m (
    .i_clk(ctrl_bus.clk), .i_rst_n(ctrl_bus.rst_n), .i_bubble(1'b0),
    .i_d(w_e), .o_q(w_m)
  );

  hazard_stage_reg u_stage_w (
    .i_clk(ctrl_bus.clk), .i_rst_n(ctrl_bus.rst_n), .i_bubble(1'b0),
    .i_d(w_m), .o_q(w_w)
  );

  assign forwardA_E = fwd_sel(w_e.rs, w_m, w_w);
  assign forwardB_E = fwd_sel(w_e.rt, w_m, w_w);
  assign forwardA_D = w_m.reg_write && id_hit(rs_D, w_m.dst);
  assign forwardB_D = w_m.reg_write && id_hit(rt_D, w_m.dst);

  assign w_lw_stall = w_e.mem_to_reg && w_e.reg_write &&
                      (id_hit(rs_D, w_e.dst) || id_hit(rt_D, w_e.dst));
  // A branch compares in decode, so it must wait for an ALU result still in E
  // and for a load result still in M.
  assign w_br_stall = branch_D &&
                      ((w_e.reg_write && (id_hit(rs_D, w_e.dst) || id_hit(rt_D, w_e.dst))) ||
                       (w_m.mem_to_reg && (id_hit(rs_D, w_m.dst) || id_hit(rt_D, w_m.dst))));
  assign w_stall    = w_lw_stall || w_br_stall;

  assign stall_F = w_stall;
  assign stall_D = w_stall;
  assign flush_E = w_stall;
  // pc_src_D is built from stale operands while stalled, so stall wins.
  assign flush_D = pc_src_D && !w_stall;

  // Fields carried along only for symmetry of the shadow stages.
  assign w_unused = ^{w_m.rs, w_m.rt, w_w.rs, w_w.rt, w_w.mem_to_reg};

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge ctrl_bus.clk or negedge ctrl_bus.rst_n) begin
    if (!ctrl_bus.rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_D && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit, plus an async-reset sequence.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       rw, mtr, br, pc;
    logic       st, fl, fad, fbd;
    logic [1:0] fae, fbe;
  } vec_t;

  ctrl_bus_if u_bus ();

  logic [4:0]  rs_D, rt_D, dst_D;
  logic        reg_write_D, mem_to_reg_D, branch_D, pc_src_D;
  logic        stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D;
  logic [1:0]  forwardA_E, forwardB_E;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit dut (
    .ctrl_bus(u_bus), .rs_D(rs_D), .rt_D(rt_D), .dst_D(dst_D),
    .reg_write_D(reg_write_D), .mem_to_reg_D(mem_to_reg_D),
    .branch_D(branch_D), .pc_src_D(pc_src_D),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial u_bus.clk = 1'b0;
  always #5 u_bus.clk = ~u_bus.clk;

  function automatic vec_t mk(input int rs, rt, dst, rw, mtr, br, pc,
                              input int st, fl, fad, fbd, fae, fbe);
    vec_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.dst = 5'(dst);
    r.rw = 1'(rw); r.mtr = 1'(mtr); r.br = 1'(br); r.pc = 1'(pc);
    r.st = 1'(st); r.fl = 1'(fl); r.fad = 1'(fad); r.fbd = 1'(fbd);
    r.fae = 2'(fae); r.fbe = 2'(fbe);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, rt, dst, rw, mtr, br, pc);
    rs_D = 5'(rs); rt_D = 5'(rt); dst_D = 5'(dst);
    reg_write_D = 1'(rw); mem_to_reg_D = 1'(mtr); branch_D = 1'(br); pc_src_D = 1'(pc);
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, stall_F, stall_D, flush_E, flush_D, forwardA_D, forwardB_D,
            forwardA_E, forwardB_E};
  endfunction

  function automatic logic [31:0] exp_outs(input logic st, fl, fad, fbd,
                                           input logic [1:0] fae, fbe);
    return {22'd0, st, st, st, fl, fad, fbd, fae, fbe};
  endfunction

  vec_t vecs[$];
  int   n_st, n_fl;
  logic [31:0] exp_sc, exp_fc;

  initial begin
    // back-to-back ALU producer of $8
    vecs.push_back(mk(0,0,8,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(8,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(8,0,0,0,0,0,0, 0,0,1,0,2,0));
    vecs.push_back(mk(9,0,0,0,0,0,0, 0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // load-use on rt
    vecs.push_back(mk(0,0,9,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,9,0,0,0,0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,9,0,0,0,0,0, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // load then dependent branch: two stalls, then taken -> flush
    vecs.push_back(mk(0,0,9,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(9,0,0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(9,0,0,0,0,1,0, 1,0,1,0,0,0));
    vecs.push_back(mk(9,0,0,0,0,1,1, 0,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // ALU $10 then beq $10,$10; pc_src during the stall must not flush
    vecs.push_back(mk(0,0,10,1,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(10,10,0,0,0,1,1, 1,0,0,0,0,0));
    vecs.push_back(mk(10,10,0,0,0,1,0, 0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // $0 producer (load) never matches
    vecs.push_back(mk(0,0,0,1,1,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0));

    // reset state; flush_D follows pc_src_D even in reset
    u_bus.rst_n = 1'b0;
    drive(0,0,0,0,0,0,1);
    #1;
    chk("reset_outs", outs(), exp_outs(0,1,0,0,0,0));
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    drive(0,0,0,0,0,0,0);
    #11 u_bus.rst_n = 1'b1;

    n_st = 0;
    n_fl = 0;
    @(posedge u_bus.clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].rw, vecs[i].mtr,
            vecs[i].br, vecs[i].pc);
      @(negedge u_bus.clk);
      chk($sformatf("vec%0d", i), outs(),
          exp_outs(vecs[i].st, vecs[i].fl, vecs[i].fad, vecs[i].fbd,
                   vecs[i].fae, vecs[i].fbe));
      if (vecs[i].st) n_st++;
      if (vecs[i].fl) n_fl++;
      @(posedge u_bus.clk); #1;
    end

`ifdef HAZARD_PERF_EN
    exp_sc = 32'(n_st);
    exp_fc = 32'(n_fl);
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    chk("stall_cnt", stall_cnt, exp_sc);
    chk("flush_cnt", flush_cnt, exp_fc);

    // async reset mid-sequence with live forwarding state
    drive(0,0,8,1,0,0,0);
    @(posedge u_bus.clk); #1;
    drive(8,0,0,0,0,0,0);
    @(posedge u_bus.clk); #1;
    drive(8,0,0,0,0,0,1);
    #1;
    chk("pre_reset_fwd", outs(), exp_outs(0,1,1,0,2,0));
    #2 u_bus.rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), exp_outs(0,1,0,0,0,0));
    chk("async_reset_stall_cnt", stall_cnt, 32'd0);
    chk("async_reset_flush_cnt", flush_cnt, 32'd0);
    @(posedge u_bus.clk);
    @(negedge u_bus.clk);
    u_bus.rst_n = 1'b1;
    drive(8,9,0,0,0,1,0);
    #1;
    chk("post_release_outs", outs(), exp_outs(0,0,0,0,0,0));
    @(posedge u_bus.clk); #1;
    drive(0,0,0,0,0,0,0);
    #1;
    chk("post_release_fwd", outs(), exp_outs(0,0,0,0,0,0));
    chk("post_release_stall_cnt", stall_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
